fpu_div_seq: RTL
================

Name: fpu_div_seq

Overview:
- Sequential IEEE-754 single-precision divider, c = a / b. It is the inverse-operation companion to the combinational FP32 multiplier top (fpu_top).
- Uses a radix-2 restoring mantissa divider, one quotient bit per clock.
- Result formats and flag outputs (flag_out, oom, vec) follow the multiplier's meaning, so the two units can sit side by side in the FPU datapath.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- QNAN, 32'h7FC0_0000, canonical quiet-NaN pattern returned for invalid operations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  unit can accept operands; high only in IDLE.
- a  input  32  dividend, FP32.
- b  input  32  divisor, FP32.
- out_valid  output  1  c and the flags are valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- c  output  32  quotient, FP32.
- flag_out  output  1  special-operand result (NaN, inf, or zero divisor involved).
- oom  output  1  exponent overflow; c forced to signed infinity.
- vec  output  1  exponent underflow; c forced to signed zero.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset state: state=IDLE; c=0, flag_out=0, oom=0, vec=0, out_valid=0. in_ready=1 during and after reset. All internal registers are cleared.
- Reset mid-operation aborts the operation immediately. No result is produced for the aborted operands.
- States: IDLE, DIV, NORM, DONE.
- in_ready = (state==IDLE). in_ready is a combinational decode of the state only.
- Accept edge (in_valid & in_ready):
  - Register s = a[31]^b[31], ea = a[30:23], eb = b[30:23].
  - Register ma = {hidden,a[22:0]} and mb = {hidden,b[22:0]}, where hidden = (exp != 0).
- Operand classes: exp==0 is zero (denormals are flushed to zero). exp==255 with frac!=0 is NaN. exp==255 with frac==0 is inf.
- Special cases, decided on the accept edge. The result is registered on that same edge, next state is DONE, and latency is 1 cycle:
  - NaN operand, 0/0, or inf/inf -> c=QNAN, flag_out=1.
  - finite nonzero / 0, or inf / finite -> c={s,8'hFF,23'h0}, flag_out=1.
  - finite / inf -> c={s,31'h0}, flag_out=1.
  - 0 / finite nonzero -> c={s,31'h0}, flag_out=0.
  - In all special cases oom=0 and vec=0.
- DIV state:
  - 25 iterations, counter 0..24. Remainder r is 25 bits and is initialised to ma.
  - Each cycle: if r>=mb then qbit=1 and r=r-mb, else qbit=0. Then r<<=1 and q={q[23:0],qbit}.
  - On the edge where the counter reaches 24, go to NORM.
- NORM state (one cycle, registers the result, then DONE):
  - If q[24]=1: mantissa=q[23:1], e = ea - eb + 127.
  - Else: mantissa=q[22:0], e = ea - eb + 126.
  - e is computed as a 10-bit signed value.
  - Rounding is truncation; no sticky bit or rounding increment.
  - If e>=255: c={s,8'hFF,23'h0}, oom=1.
  - Else if e<=0: c={s,31'h0}, vec=1.
  - Else: c={s,e[7:0],mantissa}.
  - flag_out=0 in all NORM outcomes.
- Latency: the normal path sets out_valid after the 26th rising edge following the accept edge.
- DONE state:
  - out_valid=1; c and all flags are held stable while out_ready=0.
  - On out_valid & out_ready, go to IDLE and clear out_valid.
  - c and the flags keep their last values until the next result is registered.
  - in_ready is low in DONE, so there is no same-cycle turnaround. The earliest next accept is one cycle after the handshake.
- in_valid while busy is ignored; the operands are not captured.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> c=0x40400000, flags 0, out_valid exactly 26 cycles after accept.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> c=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- Special operands, each with out_valid one cycle after accept:
  - a=0xBF800000, b=0x00000000 -> c=0xFF800000, flag_out=1.
  - a=0x00000000, b=0x00000000 -> c=0x7FC00000, flag_out=1.
- Exponent range:
  - Overflow: a=0x7F000000, b=0x3F000000 -> c=0x7F800000, oom=1, vec=0.
  - Underflow: a=0x00800000, b=0x40000000 -> c=0x00000000, vec=1.
- Back-pressure: hold out_ready=0 for 10 cycles -> c stable and in_ready=0 throughout. A new in_valid during that time is not captured.
- Reset mid-operation: drop rst_n at DIV cycle 10 -> outputs go to 0 asynchronously and in_ready=1. The next 6.0/2.0 completes correctly.

Source files
------------

// File: rtl/fpu_div_seq.sv
`timescale 1ns/1ps
// fpu_div_seq: sequential IEEE-754 single-precision divider, c = a / b.
// A radix-2 restoring mantissa divider produces one quotient bit per clock.
// Special operands are resolved in a single cycle. Results use the same flag
// meaning as the FP32 multiplier: flag_out marks a special operand, oom marks
// exponent overflow and vec marks exponent underflow.
module fpu_div_seq #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic        flag_out,
  output logic        oom,
  output logic        vec
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t state, state_nxt;

  logic              s;
  logic [7:0]        ea, eb;
  logic [23:0]       mb;
  logic [24:0]       r, q;
  logic [4:0]        cnt;

  logic              accept;
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic              sgn;
  logic              spec_hit, spec_flag;
  logic [31:0]       spec_c;

  logic [24:0]       mb_ext, r_sub, r_rem, r_nxt;
  logic              qbit;
  logic [33:0]       norm_res;

  // Pack the normalised quotient, saturating the exponent to inf or zero.
  // Returns {c[31:0], oom, vec}. Rounding is plain truncation.
  function automatic logic [33:0] norm_pack(
    input logic        sign,
    input logic [7:0]  exp_a,
    input logic [7:0]  exp_b,
    input logic [24:0] quo
  );
    logic signed [9:0] e;
    logic [22:0]       mant;
    logic [33:0]       res;
    if (quo[24]) begin
      mant = quo[23:1];
      e    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd127;
    end else begin
      mant = quo[22:0];
      e    = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + 10'sd126;
    end
    if (e >= 10'sd255)
      res = {sign, 8'hFF, 23'h0, 1'b1, 1'b0};
    else if (e <= 10'sd0)
      res = {sign, 31'h0, 1'b0, 1'b1};
    else
      res = {sign, e[7:0], mant, 1'b0, 1'b0};
    return res;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Operand classes; exp==0 is zero, denormals are flushed.
  assign a_zero = ~|a[30:23];
  assign a_inf  = (&a[30:23]) & ~|a[22:0];
  assign a_nan  = (&a[30:23]) & (|a[22:0]);
  assign b_zero = ~|b[30:23];
  assign b_inf  = (&b[30:23]) & ~|b[22:0];
  assign b_nan  = (&b[30:23]) & (|b[22:0]);
  assign sgn    = a[31] ^ b[31];

  // Resolve special-operand results from the raw inputs.
  always_comb begin
    spec_hit  = 1'b1;
    spec_flag = 1'b1;
    spec_c    = QNAN;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_c = QNAN;
    end else if (b_zero | a_inf) begin
      spec_c = {sgn, 8'hFF, 23'h0};
    end else if (b_inf) begin
      spec_c = {sgn, 31'h0};
    end else if (a_zero) begin
      spec_c    = {sgn, 31'h0};
      spec_flag = 1'b0;
    end else begin
      spec_hit  = 1'b0;
      spec_flag = 1'b0;
      spec_c    = 32'h0;
    end
  end

  // One restoring-division step: compare, conditionally subtract, shift.
  always_comb begin
    mb_ext = {1'b0, mb};
    qbit   = (r >= mb_ext);
    r_sub  = r - mb_ext;
    r_rem  = qbit ? r_sub : r;
    r_nxt  = {r_rem[23:0], 1'b0};
  end

  assign norm_res = norm_pack(s, ea, eb, q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = spec_hit ? DONE : DIV;
      DIV:  if (cnt == 5'd24) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, divider iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s        <= 1'b0;
      ea       <= 8'h0;
      eb       <= 8'h0;
      mb       <= 24'h0;
      r        <= 25'h0;
      q        <= 25'h0;
      cnt      <= 5'd0;
      c        <= 32'h0;
      flag_out <= 1'b0;
      oom      <= 1'b0;
      vec      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s   <= sgn;
            ea  <= a[30:23];
            eb  <= b[30:23];
            mb  <= {~b_zero, b[22:0]};
            r   <= {1'b0, ~a_zero, a[22:0]};
            q   <= 25'h0;
            cnt <= 5'd0;
            if (spec_hit) begin
              c        <= spec_c;
              flag_out <= spec_flag;
              oom      <= 1'b0;
              vec      <= 1'b0;
            end
          end
        end
        DIV: begin
          r   <= r_nxt;
          q   <= {q[23:0], qbit};
          cnt <= cnt + 5'd1;
        end
        NORM: begin
          c        <= norm_res[33:2];
          oom      <= norm_res[1];
          vec      <= norm_res[0];
          flag_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
